framebuffer_plot_sink: RTL and testbench
========================================

// Module: framebuffer_plot_sink
// PURPOSE
//   Receiving end of the plot/x/y/colour pixel-write stream that the drawing FSMs
//   (background, frog, cars) emit. Stores pixels in an on-chip WIDTH x HEIGHT
//   framebuffer. Provides a bulk clear engine and a row-major raster reader that
//   streams the frame out over a valid/ready handshake, for scan-out and readback.
// PARAMETERS
//   WIDTH        160   pixels per row; x range 0..WIDTH-1
//   HEIGHT       120   rows; y range 0..HEIGHT-1
//   COLOUR_W     3     bits per pixel
//   CLEAR_COLOUR 3'b000 value written by the clear engine
// PORTS
//   clock        in   1   single clock; all logic on its rising edge
//   reset        in   1   synchronous, active-high reset
//   plot         in   1   write strobe; one pixel per cycle when high
//   x            in   8   write column
//   y            in   7   write row
//   colour       in   COLOUR_W  write data
//   start_clear  in   1   one-cycle request: fill every pixel with CLEAR_COLOUR
//   start_scan   in   1   one-cycle request: stream the whole frame out
//   busy         out  1   high while in CLEAR or SCAN
//   pix_valid    out  1   output pixel is valid
//   pix_ready    in   1   consumer accepts the pixel when pix_valid & pix_ready
//   pix_x        out  8   column of the output pixel
//   pix_y        out  7   row of the output pixel
//   pix_colour   out  COLOUR_W  stored colour of the output pixel
//   frame_done   out  1   one-cycle pulse when a clear or scan completes
// BEHAVIOUR
// - Memory: WIDTH*HEIGHT words, addr = y*WIDTH + x (15 bits). Synchronous read,
//   1-cycle latency. RAM contents are not touched by reset.
// - Reset: state IDLE. busy, pix_valid, frame_done = 0. pix_x, pix_y, pix_colour = 0.
//   Reset in the middle of CLEAR or SCAN aborts the operation in the same cycle.
//   No frame_done pulse is produced. Partially cleared RAM is left as is.
// - FSM states: IDLE, CLEAR, SCAN, DONE.
//   IDLE -> CLEAR on start_clear. IDLE -> SCAN on start_scan. If both are high
//   in the same cycle, CLEAR wins and the scan request is dropped.
//   CLEAR: writes one address per cycle, 0..WIDTH*HEIGHT-1. After the last
//   address the FSM enters DONE. busy is high for exactly WIDTH*HEIGHT cycles.
//   SCAN: the address counter runs row-major from (0,0) to (WIDTH-1,HEIGHT-1).
//   The FSM enters DONE in the cycle after the last pixel is accepted.
//   DONE: frame_done = 1 for one cycle, then the FSM returns to IDLE.
//   A start_* request seen outside IDLE is ignored.
// - Plot writes: accepted in IDLE, SCAN and DONE. A write is ignored when
//   x >= WIDTH or y >= HEIGHT. Plot writes are ignored while in CLEAR.
// - Read/write collision: a read and a plot write to the same address in the
//   same cycle return the old data.
// - Scan handshake:
//   The first pix_valid rises 2 cycles after the start_scan cycle.
//   While pix_valid & !pix_ready, pix_x, pix_y and pix_colour hold stable.
//   Use a skid/holding register so that no pixel is lost or duplicated.
//   With pix_ready held high the stream is gap-free: one pixel per cycle and
//   WIDTH*HEIGHT consecutive valid beats.
//   pix_x wraps WIDTH-1 -> 0 and pix_y then increments. After the final pixel,
//   pix_valid drops.
// - Width rules: x, y are compared unsigned against WIDTH, HEIGHT. The address
//   multiply is exact in 15 bits for the default parameters.
// TESTING
// - Write plot x=25,y=20,colour=100, then scan with ready=1 -> beat 3225
//   shows pix_x=25, pix_y=20, pix_colour=100.
// - Write x=160,y=5 and x=3,y=120 -> no RAM change. Scan shows the prior
//   contents at (0,5) and (3,0).
// - start_clear -> busy high exactly 19200 cycles, frame_done pulse in the
//   next cycle. A following scan returns 000 for all 19200 beats. Plot writes
//   during the clear are dropped.
// - Mid-scan at beat 500, hold pix_ready=0 for 5 cycles -> pix_valid=1 and
//   the outputs hold (x=20,y=3). The stream resumes with no loss or duplication.
//   Total accepted beats = 19200.
// - start_clear and start_scan in the same cycle -> CLEAR runs and no pixel
//   is streamed. A start_scan pulsed during CLEAR is ignored.
// - Assert reset at scan beat 1000 -> next cycle busy=0, pix_valid=0, no
//   frame_done pulse. A new start_scan restarts from (0,0).

Source files
------------

// File: rtl/framebuffer_plot_sink.sv
// framebuffer_plot_sink: on-chip WIDTH x HEIGHT pixel store fed by plot writes,
// with a bulk clear engine and a row-major valid/ready raster reader.
module framebuffer_plot_sink #(
    parameter int                  WIDTH        = 160,
    parameter int                  HEIGHT       = 120,
    parameter int                  COLOUR_W     = 3,
    parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                plot,
    input  logic [7:0]          x,
    input  logic [6:0]          y,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                start_clear,
    input  logic                start_scan,
    output logic                busy,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic [7:0]          pix_x,
    output logic [6:0]          pix_y,
    output logic [COLOUR_W-1:0] pix_colour,
    output logic                frame_done
);
    localparam int            N    = WIDTH * HEIGHT;
    localparam int            AW   = $clog2(N);
    localparam logic [AW-1:0] LAST = AW'(N - 1);
    localparam logic [7:0]    XMAX = 8'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

    state_t              state, next;
    logic [AW-1:0]       cnt, plot_addr, wa;
    logic [7:0]          rx, q_x;
    logic [6:0]          ry, q_y;
    logic                rd_done, rd_en, q_valid, in_range, we;
    logic [COLOUR_W-1:0] ram_q, wd;
    logic [COLOUR_W-1:0] mem [N];

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        if (state == IDLE)
            next = start_clear ? CLEAR : start_scan ? SCAN : IDLE;
        else if (state == CLEAR)
            next = (cnt == LAST) ? DONE : CLEAR;
        else if (state == SCAN)
            next = (rd_done && q_valid && pix_ready) ? DONE : SCAN;
        else
            next = IDLE;
    end

    assign busy       = (state == CLEAR) || (state == SCAN);
    assign frame_done = (state == DONE);
    assign in_range   = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    assign plot_addr  = AW'(y) * AW'(WIDTH) + AW'(x);
    assign we         = !reset && ((state == CLEAR) || (plot && in_range));
    assign wa         = (state == CLEAR) ? cnt : plot_addr;
    assign wd         = (state == CLEAR) ? CLEAR_COLOUR : colour;

    // A new read is only launched when the output slot frees up this cycle,
    // so the enabled RAM output register doubles as the stall holding register.
    assign rd_en = (state == SCAN) && !rd_done && (!q_valid || pix_ready);

    always_ff @(posedge clock) begin
        if (we)
            mem[wa] <= wd;
        if (rd_en)
            ram_q <= mem[cnt];
    end

    always_ff @(posedge clock) begin
        if (reset || state == IDLE) begin
            cnt     <= '0;
            rx      <= '0;
            ry      <= '0;
            rd_done <= 1'b0;
        end else if (state == CLEAR) begin
            cnt <= cnt + 1'b1;
        end else if (rd_en) begin
            cnt     <= cnt + 1'b1;
            rd_done <= (cnt == LAST);
            rx      <= (rx == XMAX) ? '0 : rx + 1'b1;
            ry      <= (rx == XMAX) ? ry + 1'b1 : ry;
        end
    end

    always_ff @(posedge clock) begin
        if (rd_en) begin
            q_x <= rx;
            q_y <= ry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            q_valid <= 1'b0;
        else if (rd_en)
            q_valid <= 1'b1;
        else if (pix_ready)
            q_valid <= 1'b0;
    end

    assign pix_valid  = q_valid;
    assign pix_x      = q_valid ? q_x : '0;
    assign pix_y      = q_valid ? q_y : '0;
    assign pix_colour = q_valid ? ram_q : '0;

endmodule

// File: tb/tb_framebuffer_plot_sink.sv
// tb_framebuffer_plot_sink: randomized plot/clear/scan traffic checked against
// a flat array model of the frame indexed by y*W+x.
module tb_framebuffer_plot_sink;
    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic       clock = 1'b0;
    logic       reset, plot, start_clear, start_scan, pix_ready;
    logic [7:0] x, pix_x;
    logic [6:0] y, pix_y;
    logic [2:0] colour, pix_colour;
    logic       busy, pix_valid, frame_done;

    logic [2:0] model [N];
    int checks = 0;
    int errors = 0;

    framebuffer_plot_sink dut (
        .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
        .start_clear(start_clear), .start_scan(start_scan), .busy(busy),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_colour(pix_colour), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic wr(input int px, input int py, input int pc);
        plot   = 1'b1;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        if (px < W && py < H)
            model[py * W + px] = 3'(pc);
        @(negedge clock);
        plot = 1'b0;
    endtask

    task automatic do_clear(input logic both);
        int n;
        start_clear = 1'b1;
        start_scan  = both;
        @(negedge clock);
        start_clear = 1'b0;
        start_scan  = 1'b0;
        n = 0;
        while (busy && n < 25000) begin
            n++;
            check("clear_no_stream", int'(pix_valid), 0);
            start_scan = (n == 100);
            plot       = 1'b1;
            x          = 8'($urandom_range(W - 1));
            y          = 7'($urandom_range(H - 1));
            colour     = 3'($urandom_range(7, 1));
            @(negedge clock);
        end
        plot       = 1'b0;
        start_scan = 1'b0;
        check("clear_busy_cycles", n, N);
        check("clear_done", int'(frame_done), 1);
        @(negedge clock);
        check("clear_done_pulse", int'(frame_done), 0);
        for (int i = 0; i < N; i++)
            model[i] = 3'b000;
        repeat (3) begin
            check("clear_idle_valid", int'(pix_valid), 0);
            check("clear_idle_busy", int'(busy), 0);
            @(negedge clock);
        end
    endtask

    task automatic do_scan(input int pct, input int stall_at, input int abort_at, input bit spot);
        int b, cyc, first, last, stall;
        b = 0; cyc = 1; first = -1; last = 0; stall = 0;
        start_scan = 1'b1;
        @(negedge clock);
        start_scan = 1'b0;
        while (b < N && b != abort_at && cyc < 40000) begin
            if (pix_valid && first < 0) begin
                first = cyc;
                check("first_valid_cycle", cyc, 2);
            end
            if (b == stall_at && stall < 5 && (stall > 0 || pix_valid)) begin
                pix_ready = 1'b0;
                stall++;
                check("stall_valid", int'(pix_valid), 1);
                check("stall_x", int'(pix_x), b % W);
                check("stall_y", int'(pix_y), b / W);
                check("stall_colour", int'(pix_colour), int'(model[b]));
            end else begin
                pix_ready = ($urandom_range(99) < pct);
            end
            if (pix_valid && pix_ready) begin
                check("beat_x", int'(pix_x), b % W);
                check("beat_y", int'(pix_y), b / W);
                check("beat_colour", int'(pix_colour), int'(model[b]));
                if (spot && b == 3225) begin
                    check("spot_3225_x", int'(pix_x), 25);
                    check("spot_3225_y", int'(pix_y), 20);
                    check("spot_3225_colour", int'(pix_colour), 4);
                end
                if (spot && b == 800)
                    check("spot_0_5_colour", int'(pix_colour), 6);
                if (spot && b == 3)
                    check("spot_3_0_colour", int'(pix_colour), 5);
                b++;
                last = cyc;
            end
            @(negedge clock);
            cyc++;
        end
        pix_ready = 1'b1;
        if (b == abort_at) begin
            reset = 1'b1;
            @(negedge clock);
            reset = 1'b0;
            check("abort_busy", int'(busy), 0);
            check("abort_valid", int'(pix_valid), 0);
            check("abort_done", int'(frame_done), 0);
            repeat (3) begin
                @(negedge clock);
                check("abort_no_done", int'(frame_done), 0);
                check("abort_idle_valid", int'(pix_valid), 0);
            end
            return;
        end
        check("scan_beats", b, N);
        if (pct == 100)
            check("gap_free_span", last - first + 1, N);
        if (stall_at >= 0)
            check("stall_cycles", stall, 5);
        check("scan_done", int'(frame_done), 1);
        check("scan_done_busy", int'(busy), 0);
        check("scan_valid_after", int'(pix_valid), 0);
        @(negedge clock);
        check("scan_done_pulse", int'(frame_done), 0);
    endtask

    initial begin
        reset = 1'b1; plot = 1'b0; x = '0; y = '0; colour = '0;
        start_clear = 1'b0; start_scan = 1'b0; pix_ready = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(pix_valid), 0);
        check("reset_done", int'(frame_done), 0);
        check("reset_x", int'(pix_x), 0);
        check("reset_y", int'(pix_y), 0);
        check("reset_colour", int'(pix_colour), 0);
        @(negedge clock);
        // simultaneous requests: clear wins, scan is dropped, mid-clear scan ignored
        do_clear(1'b1);
        do_scan(100, -1, -1, 1'b0);
        for (int i = 0; i < 300; i++)
            wr(int'($urandom_range(175)), int'($urandom_range(127)), int'($urandom_range(7)));
        wr(0, 5, 6);
        wr(3, 0, 5);
        wr(25, 20, 4);
        wr(160, 5, 7);
        wr(3, 120, 7);
        do_scan(85, 500, -1, 1'b1);
        do_scan(100, -1, 1000, 1'b0);
        do_scan(100, -1, 5, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
